// File: rtl/mem_access_stage_pkg.sv
// Shared constants for the memory-access stage: widths, mem_ctrl bit positions,
// access-size encodings and the handshake FSM state type.
package mem_access_stage_pkg;

    localparam int DEF_WIDTH         = 32;
    localparam int DEF_R_WIDTH       = 5;
    localparam int MEM_CTRL_WIDTH    = 5;
    localparam int DEF_WB_CTRL_WIDTH = 2;

    // mem_ctrl = {mem_read, mem_write, size[1:0], unsigned}
    localparam int MC_READ     = 4;
    localparam int MC_WRITE    = 3;
    localparam int MC_SIZE_HI  = 2;
    localparam int MC_SIZE_LO  = 1;
    localparam int MC_UNSIGNED = 0;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store replicate + byte enables, load lane
// extract with sign/zero extension. Size 11 behaves as a word access.
module mem_lane_align
    import mem_access_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [1:0]       addr_lo_i,
    input  logic [1:0]       size_i,
    input  logic             unsigned_i,
    input  logic [WIDTH-1:0] st_data_i,
    input  logic [WIDTH-1:0] ld_raw_i,
    output logic [3:0]       be_o,
    output logic [WIDTH-1:0] wdata_o,
    output logic [WIDTH-1:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte   = ld_raw_i[{addr_lo_i, 3'b000} +: 8];
        ld_half   = addr_lo_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];
        be_o      = 4'b1111;
        wdata_o   = st_data_i;
        ld_data_o = ld_raw_i;
        case (size_i)
            SZ_BYTE: begin
                be_o      = 4'b0001 << addr_lo_i;
                wdata_o   = {(WIDTH/8){st_data_i[7:0]}};
                ld_data_o = {{(WIDTH-8){~unsigned_i & ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                // odd half addresses fall back to the enclosing aligned half
                be_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o   = {(WIDTH/16){st_data_i[15:0]}};
                ld_data_o = {{(WIDTH-16){~unsigned_i & ld_half[15]}}, ld_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM consumer: data-memory req/ack handshake, store alignment, load extension,
// MEM/WB register. Optional MEM_MISALIGN_CHECK_EN drops misaligned half/word accesses.
//
// state   | meaning
// ST_IDLE | no access outstanding; non-memops pass straight to MEM/WB
// ST_WAIT | request issued and held; waiting for dmem_ack_i
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int R_WIDTH       = DEF_R_WIDTH,
    parameter int WB_CTRL_WIDTH = DEF_WB_CTRL_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    input  logic [MEM_CTRL_WIDTH-1:0] mem_ctrl_i,
    input  logic [WB_CTRL_WIDTH-1:0]  wb_ctrl_i,
    input  logic [WIDTH-1:0]          result_i,
    input  logic [WIDTH-1:0]          src2_i,
    input  logic [R_WIDTH-1:0]        rd_i,
    output logic                      stall_o,
    output logic                      dmem_req_o,
    output logic                      dmem_we_o,
    output logic [WIDTH-1:0]          dmem_addr_o,
    output logic [3:0]                dmem_be_o,
    output logic [WIDTH-1:0]          dmem_wdata_o,
    input  logic [WIDTH-1:0]          dmem_rdata_i,
    input  logic                      dmem_ack_i,
    output logic                      valid_o,
    output logic [WB_CTRL_WIDTH-1:0]  wb_ctrl_o,
    output logic [WIDTH-1:0]          alu_result_o,
    output logic [WIDTH-1:0]          load_data_o,
    output logic [R_WIDTH-1:0]        rd_o
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic                      misalign_o
`endif
);

    mem_state_e                 state_q;
    logic                       hold_we_q;
    logic [1:0]                 hold_size_q;
    logic                       hold_uns_q;
    logic [WB_CTRL_WIDTH-1:0]   hold_wb_q;
    logic [WIDTH-1:0]           hold_result_q;
    logic [R_WIDTH-1:0]         hold_rd_q;

    logic                       dmem_req_q, dmem_we_q;
    logic [WIDTH-1:0]           dmem_addr_q, dmem_wdata_q;
    logic [3:0]                 dmem_be_q;
    logic                       valid_q;
    logic [WB_CTRL_WIDTH-1:0]   wb_ctrl_q;
    logic [WIDTH-1:0]           alu_result_q, load_data_q, rd_unused_pad;
    logic [R_WIDTH-1:0]         rd_q;

    logic                       memop, in_wait, misalign_hit, issue;
    logic [1:0]                 sel_addr, sel_size, cur_size;
    logic                       sel_uns;
    logic [3:0]                 be_d;
    logic [WIDTH-1:0]           wdata_d, ld_ext, addr_d, load_d;

    assign cur_size = mem_ctrl_i[MC_SIZE_HI:MC_SIZE_LO];
    assign memop    = valid_i & (mem_ctrl_i[MC_READ] | mem_ctrl_i[MC_WRITE]);
    assign in_wait  = (state_q == ST_WAIT);

    // one aligner serves both directions: store fields in IDLE, held load fields in WAIT
    assign sel_addr = in_wait ? hold_result_q[1:0] : result_i[1:0];
    assign sel_size = in_wait ? hold_size_q : cur_size;
    assign sel_uns  = in_wait ? hold_uns_q : mem_ctrl_i[MC_UNSIGNED];

    mem_lane_align #(.WIDTH(WIDTH)) u_align (
        .addr_lo_i  (sel_addr),
        .size_i     (sel_size),
        .unsigned_i (sel_uns),
        .st_data_i  (src2_i),
        .ld_raw_i   (dmem_rdata_i),
        .be_o       (be_d),
        .wdata_o    (wdata_d),
        .ld_data_o  (ld_ext)
    );

`ifdef MEM_MISALIGN_CHECK_EN
    logic misalign_q;
    assign misalign_hit = memop & (((cur_size == SZ_HALF) & result_i[0])
                                 | (cur_size[1] & (result_i[1:0] != 2'b00)));
    assign misalign_o   = misalign_q;
`else
    assign misalign_hit = 1'b0;
`endif

    assign issue         = memop & ~misalign_hit;
    assign stall_o       = in_wait ? ~dmem_ack_i : issue;
    assign addr_d        = {result_i[WIDTH-1:2], 2'b00};
    assign load_d        = hold_we_q ? '0 : ld_ext;
    assign rd_unused_pad = '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            hold_we_q     <= 1'b0;
            hold_size_q   <= 2'b00;
            hold_uns_q    <= 1'b0;
            hold_wb_q     <= '0;
            hold_result_q <= '0;
            hold_rd_q     <= '0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= '0;
            dmem_be_q     <= 4'b0000;
            dmem_wdata_q  <= '0;
            valid_q       <= 1'b0;
            wb_ctrl_q     <= '0;
            alu_result_q  <= '0;
            load_data_q   <= '0;
            rd_q          <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        state_q       <= ST_WAIT;
                        dmem_req_q    <= 1'b1;
                        dmem_we_q     <= mem_ctrl_i[MC_WRITE];
                        dmem_addr_q   <= addr_d;
                        dmem_be_q     <= be_d;
                        dmem_wdata_q  <= wdata_d;
                        hold_we_q     <= mem_ctrl_i[MC_WRITE];
                        hold_size_q   <= cur_size;
                        hold_uns_q    <= mem_ctrl_i[MC_UNSIGNED];
                        hold_wb_q     <= wb_ctrl_i;
                        hold_result_q <= result_i;
                        hold_rd_q     <= rd_i;
                        valid_q       <= 1'b0;
                    end else begin
                        valid_q       <= valid_i & ~misalign_hit;
                        wb_ctrl_q     <= wb_ctrl_i;
                        alu_result_q  <= result_i;
                        rd_q          <= rd_i;
                        load_data_q   <= rd_unused_pad;
                    end
`ifdef MEM_MISALIGN_CHECK_EN
                    misalign_q <= misalign_hit;
`endif
                end
                ST_WAIT: begin
                    if (dmem_ack_i) begin
                        state_q      <= ST_IDLE;
                        dmem_req_q   <= 1'b0;
                        valid_q      <= 1'b1;
                        wb_ctrl_q    <= hold_wb_q;
                        alu_result_q <= hold_result_q;
                        rd_q         <= hold_rd_q;
                        load_data_q  <= load_d;
                    end else begin
                        valid_q      <= 1'b0;
                    end
`ifdef MEM_MISALIGN_CHECK_EN
                    misalign_q <= 1'b0;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dmem_req_o   = dmem_req_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_be_o    = dmem_be_q;
    assign dmem_wdata_o = dmem_wdata_q;
    assign valid_o      = valid_q;
    assign wb_ctrl_o    = wb_ctrl_q;
    assign alu_result_o = alu_result_q;
    assign load_data_o  = load_data_q;
    assign rd_o         = rd_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a byte-arithmetic reference model.
// Define MEM_MISALIGN_CHECK_EN to exercise the misalignment-drop feature.
module tb_mem_access_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [4:0]  mem_ctrl_i = '0;
    logic [1:0]  wb_ctrl_i = '0;
    logic [31:0] result_i = '0, src2_i = '0, dmem_rdata_i = '0;
    logic [4:0]  rd_i = '0;
    logic        dmem_ack_i = 1'b0;
    logic        stall_o, dmem_req_o, dmem_we_o, valid_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, alu_result_o, load_data_o;
    logic [3:0]  dmem_be_o;
    logic [1:0]  wb_ctrl_o;
    logic [4:0]  rd_o;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    mem_access_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .mem_ctrl_i(mem_ctrl_i),
        .wb_ctrl_i(wb_ctrl_i), .result_i(result_i), .src2_i(src2_i), .rd_i(rd_i),
        .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i), .valid_o(valid_o),
        .wb_ctrl_o(wb_ctrl_o), .alu_result_o(alu_result_o), .load_data_o(load_data_o),
        .rd_o(rd_o)
`ifdef MEM_MISALIGN_CHECK_EN
        , .misalign_o(misalign_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input int a);
        int n = nbytes(sz);
        int base = a - (a % n);
        return 4'(((1 << n) - 1) << base);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        int n = nbytes(sz);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                           input int a, input logic [31:0] rd);
        int n = nbytes(sz);
        int base = a - (a % n);
        logic [63:0] mask = (64'd1 << (8*n)) - 64'd1;
        logic [31:0] v = 32'((64'(rd) >> (8*base)) & mask);
        if (!uns && n < 4 && v[8*n-1]) v = v | ~32'(mask);
        return v;
    endfunction

    task automatic do_nonmem(input logic v, input logic [1:0] wb, input logic [31:0] res,
                             input logic [4:0] rdx, input logic ack_noise);
        valid_i      = v;
        mem_ctrl_i   = v ? {2'b00, 3'($urandom)} : 5'($urandom);
        wb_ctrl_i    = wb;
        result_i     = res;
        src2_i       = $urandom;
        rd_i         = rdx;
        dmem_rdata_i = $urandom;
        dmem_ack_i   = ack_noise;
        #1;
        check_eq("stall_nonmem", 32'(stall_o), 32'd0);
        step();
        check_eq("valid_nonmem", 32'(valid_o), 32'(v));
        check_eq("req_nonmem", 32'(dmem_req_o), 32'd0);
`ifdef MEM_MISALIGN_CHECK_EN
        check_eq("misalign_nonmem", 32'(misalign_o), 32'd0);
`endif
        if (v) begin
            check_eq("rd_nonmem", 32'(rd_o), 32'(rdx));
            check_eq("alu_nonmem", alu_result_o, res);
            check_eq("wb_nonmem", 32'(wb_ctrl_o), 32'(wb));
            check_eq("load_nonmem", load_data_o, 32'd0);
        end
    endtask

    task automatic do_memop(input logic rd_en, input logic wr_en, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr, input logic [31:0] s2,
                            input logic [31:0] rdata, input logic [1:0] wb,
                            input logic [4:0] rdx, input int delay);
        int a = int'(addr[1:0]);
        int cnt = 0;
        logic mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        mis = ((a % nbytes(sz)) != 0);
`endif
        valid_i    = 1'b1;
        mem_ctrl_i = {rd_en, wr_en, sz, uns};
        wb_ctrl_i  = wb;
        result_i   = addr;
        src2_i     = s2;
        rd_i       = rdx;
        dmem_ack_i = 1'b0;
        #1;
`ifdef MEM_MISALIGN_CHECK_EN
        if (mis) begin
            check_eq("stall_misalign", 32'(stall_o), 32'd0);
            step();
            check_eq("req_misalign", 32'(dmem_req_o), 32'd0);
            check_eq("valid_misalign", 32'(valid_o), 32'd0);
            check_eq("misalign_flag", 32'(misalign_o), 32'd1);
            return;
        end
`endif
        cnt += int'(stall_o);
        check_eq("stall_issue", 32'(stall_o), 32'(!mis));
        step();
        check_eq("req_issue", 32'(dmem_req_o), 32'd1);
        check_eq("we_issue", 32'(dmem_we_o), 32'(wr_en));
        check_eq("addr_issue", dmem_addr_o, addr & 32'hFFFF_FFFC);
        check_eq("be_issue", 32'(dmem_be_o), 32'(m_be(sz, a)));
        check_eq("wdata_issue", dmem_wdata_o, m_wdata(sz, s2));
        check_eq("valid_bubble", 32'(valid_o), 32'd0);
        for (int i = 0; i < delay; i++) begin
            valid_i      = 1'($urandom);
            mem_ctrl_i   = 5'($urandom);
            result_i     = $urandom;
            src2_i       = $urandom;
            rd_i         = 5'($urandom);
            dmem_rdata_i = $urandom;
            #1;
            cnt += int'(stall_o);
            check_eq("stall_wait", 32'(stall_o), 32'd1);
            step();
            check_eq("req_held", 32'(dmem_req_o), 32'd1);
            check_eq("addr_held", dmem_addr_o, addr & 32'hFFFF_FFFC);
            check_eq("be_held", 32'(dmem_be_o), 32'(m_be(sz, a)));
            check_eq("wdata_held", dmem_wdata_o, m_wdata(sz, s2));
            check_eq("we_held", 32'(dmem_we_o), 32'(wr_en));
            check_eq("valid_wait", 32'(valid_o), 32'd0);
        end
        valid_i      = 1'b1;
        mem_ctrl_i   = {rd_en, wr_en, sz, uns};
        result_i     = addr;
        src2_i       = s2;
        rd_i         = rdx;
        dmem_rdata_i = rdata;
        dmem_ack_i   = 1'b1;
        #1;
        cnt += int'(stall_o);
        check_eq("stall_ack", 32'(stall_o), 32'd0);
        step();
        check_eq("valid_done", 32'(valid_o), 32'd1);
        check_eq("rd_done", 32'(rd_o), 32'(rdx));
        check_eq("alu_done", alu_result_o, addr);
        check_eq("wb_done", 32'(wb_ctrl_o), 32'(wb));
        check_eq("load_done", load_data_o, wr_en ? 32'd0 : m_load(sz, uns, a, rdata));
        check_eq("req_drop", 32'(dmem_req_o), 32'd0);
        check_eq("stall_cycles", 32'(cnt), 32'(delay + 1));
        dmem_ack_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        check_eq("rst_valid", 32'(valid_o), 32'd0);
        check_eq("rst_req", 32'(dmem_req_o), 32'd0);
        check_eq("rst_addr", dmem_addr_o, 32'd0);
        check_eq("rst_be", 32'(dmem_be_o), 32'd0);
        check_eq("rst_alu", alu_result_o, 32'd0);
        check_eq("rst_stall", 32'(stall_o), 32'd0);

        do_nonmem(1'b1, 2'b01, 32'h0000_1234, 5'd5, 1'b0);
        do_memop(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 2'b10, 5'd7, 3);
        check_eq("sb_load_zero", load_data_o, 32'd0);
        do_memop(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_2002, 32'h0, 32'h0080_0000, 2'b11, 5'd9, 1);
        check_eq("lb_signed", load_data_o, 32'hFFFF_FF80);
        do_memop(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_2002, 32'h0, 32'h0080_0000, 2'b11, 5'd9, 2);
        check_eq("lbu_zero", load_data_o, 32'h0000_0080);
        do_memop(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_2000, 32'h0, 32'hDEAD_BEEF, 2'b01, 5'd3, 0);
        check_eq("lw_data", load_data_o, 32'hDEAD_BEEF);
        do_nonmem(1'b1, 2'b00, 32'h0000_0042, 5'd4, 1'b0);
`ifdef MEM_MISALIGN_CHECK_EN
        do_memop(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3002, 32'h0, 32'h1, 2'b01, 5'd6, 0);
        do_nonmem(1'b1, 2'b00, 32'h0000_0001, 5'd1, 1'b0);
`endif

        // reset while a request is outstanding, then a stray ack
        valid_i    = 1'b1;
        mem_ctrl_i = 5'b10100;
        result_i   = 32'h0000_4000;
        dmem_ack_i = 1'b0;
        step();
        check_eq("rstw_req_before", 32'(dmem_req_o), 32'd1);
        rst_i   = 1'b1;
        valid_i = 1'b0;
        step();
        rst_i = 1'b0;
        check_eq("rstw_req", 32'(dmem_req_o), 32'd0);
        check_eq("rstw_valid", 32'(valid_o), 32'd0);
        check_eq("rstw_stall", 32'(stall_o), 32'd0);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h5555_5555;
        step();
        check_eq("late_ack_req", 32'(dmem_req_o), 32'd0);
        check_eq("late_ack_valid", 32'(valid_o), 32'd0);
        check_eq("late_ack_load", load_data_o, 32'd0);
        dmem_ack_i = 1'b0;

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) < 3) begin
                do_nonmem(1'($urandom), 2'($urandom), $urandom, 5'($urandom), 1'($urandom));
            end else begin
                int mode = $urandom_range(0, 2);
                do_memop(mode != 1, mode != 0, 2'($urandom), 1'($urandom), $urandom,
                         $urandom, $urandom, 2'($urandom), 5'($urandom),
                         $urandom_range(0, 4));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
